// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - registered AES forward S-box over a masked byte matrix
module aes_sbox #(
    parameter int NO_ROWS = 4,
    parameter int NO_COLS = 4
) (
    input  logic               aes_clk,
    input  logic               resetn,
    input  logic               sbox_en,
    input  logic [7:0]         sbox_ip_char_matrix [NO_ROWS-1:0][NO_COLS-1:0],
    input  logic [NO_ROWS-1:0] sbox_ip_char_row_mask,
    input  logic [NO_COLS-1:0] sbox_ip_char_col_mask,
    output logic               sbox_op_char_matrix_valid,
    output logic [7:0]         sbox_op_char_matrix [NO_ROWS-1:0][NO_COLS-1:0]
);

    // FIPS-197 forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0] next_matrix [NO_ROWS-1:0][NO_COLS-1:0];

    // One ROM lookup per element; a byte is substituted only where its row and column are both selected.
    for (genvar gi = 0; gi < NO_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < NO_COLS; gj++) begin : g_col
            assign next_matrix[gi][gj] =
                (sbox_ip_char_row_mask[gi] & sbox_ip_char_col_mask[gj])
                    ? SBOX[sbox_ip_char_matrix[gi][gj]]
                    : sbox_ip_char_matrix[gi][gj];
        end
    end

    // Output register: loads on enable, holds otherwise; valid tracks whether this edge sampled.
    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            sbox_op_char_matrix_valid <= 1'b0;
            for (int i = 0; i < NO_ROWS; i++) begin
                for (int j = 0; j < NO_COLS; j++) begin
                    sbox_op_char_matrix[i][j] <= 8'h00;
                end
            end
        end else begin
            sbox_op_char_matrix_valid <= sbox_en;
            if (sbox_en) begin
                sbox_op_char_matrix <= next_matrix;
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox.sv
// tb/tb_aes_sbox.sv - randomized self-checking bench for aes_sbox
module tb_aes_sbox;

    logic       aes_clk = 1'b0;
    logic       resetn;
    logic       sbox_en;
    logic [7:0] ip  [3:0][3:0];
    logic [3:0] row_mask;
    logic [3:0] col_mask;
    logic       valid;
    logic [7:0] op  [3:0][3:0];

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_sbox [0:255];
    logic [7:0] exp_m [3:0][3:0];

    aes_sbox #(.NO_ROWS(4), .NO_COLS(4)) dut (
        .aes_clk                   (aes_clk),
        .resetn                    (resetn),
        .sbox_en                   (sbox_en),
        .sbox_ip_char_matrix       (ip),
        .sbox_ip_char_row_mask     (row_mask),
        .sbox_ip_char_col_mask     (col_mask),
        .sbox_op_char_matrix_valid (valid),
        .sbox_op_char_matrix       (op)
    );

    always #5 aes_clk = ~aes_clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, a);
        if (a == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [7:0] model_byte(input int i, input int j);
        return (row_mask[i] && col_mask[j]) ? ref_sbox[ip[i][j]] : ip[i][j];
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                ip[i][j] = v;
    endtask

    task automatic test_reset;
        resetn = 1'b0; sbox_en = 1'b0; row_mask = 4'h0; col_mask = 4'h0; fill(8'hA5);
        repeat (2) @(negedge aes_clk);
        resetn = 1'b1;
        repeat (3) @(negedge aes_clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (op[i][j] !== 8'h00) begin errors++; $display("FAIL reset_byte[%0d][%0d] got %h want 00", i, j, op[i][j]); end
            end
    endtask

    task automatic test_all_zero;
        fill(8'h00); row_mask = 4'hF; col_mask = 4'hF; sbox_en = 1'b1;
        @(negedge aes_clk);
        sbox_en = 1'b0;
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0b want 1", valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (op[i][j] !== 8'h63) begin errors++; $display("FAIL zero_byte[%0d][%0d] got %h want 63", i, j, op[i][j]); end
            end
    endtask

    task automatic test_fips_row;
        logic [7:0] r0_in  [4] = '{8'h19, 8'ha0, 8'h9a, 8'he9};
        logic [7:0] r0_out [4] = '{8'hd4, 8'he0, 8'hb8, 8'h1e};
        logic [7:0] want;
        fill(8'hFF);
        for (int j = 0; j < 4; j++) ip[0][j] = r0_in[j];
        row_mask = 4'hF; col_mask = 4'hF; sbox_en = 1'b1;
        @(negedge aes_clk);
        sbox_en = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                want = (i == 0) ? r0_out[j] : 8'h16;
                checks++;
                if (op[i][j] !== want) begin errors++; $display("FAIL fips_byte[%0d][%0d] got %h want %h", i, j, op[i][j], want); end
            end
    endtask

    task automatic test_single_mask;
        logic [7:0] want;
        fill(8'h53); row_mask = 4'b0001; col_mask = 4'b0100; sbox_en = 1'b1;
        @(negedge aes_clk);
        sbox_en = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                want = (i == 0 && j == 2) ? 8'hED : 8'h53;
                checks++;
                if (op[i][j] !== want) begin errors++; $display("FAIL mask_byte[%0d][%0d] got %h want %h", i, j, op[i][j], want); end
            end
    endtask

    task automatic test_back_to_back;
        logic [7:0] want [3] = '{8'h7C, 8'h16, 8'h16};
        logic       wv   [3] = '{1'b1, 1'b1, 1'b0};
        row_mask = 4'hF; col_mask = 4'hF;
        fill(8'h01); sbox_en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge aes_clk);
            if (s == 0) fill(8'hFF);
            if (s == 1) begin sbox_en = 1'b0; fill(8'h00); end
            checks++;
            if (valid !== wv[s]) begin errors++; $display("FAIL b2b_valid step%0d got %0b want %0b", s, valid, wv[s]); end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    checks++;
                    if (op[i][j] !== want[s]) begin errors++; $display("FAIL b2b_byte step%0d [%0d][%0d] got %h want %h", s, i, j, op[i][j], want[s]); end
                end
        end
    endtask

    task automatic test_random;
        logic exp_v = 1'b0;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    ip[i][j] = 8'($urandom_range(0, 255));
            row_mask = 4'($urandom_range(0, 15));
            col_mask = 4'($urandom_range(0, 15));
            if (n % 10 == 0) begin row_mask = 4'hF; col_mask = 4'hF; end
            if (n % 10 == 5) row_mask = 4'h0;
            sbox_en = ($urandom_range(0, 3) != 0) || (n == 0);
            if (sbox_en) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        exp_m[i][j] = model_byte(i, j);
            end
            exp_v = sbox_en;
            @(negedge aes_clk);
            checks++;
            if (valid !== exp_v) begin errors++; $display("FAIL rand_valid iter%0d got %0b want %0b", n, valid, exp_v); end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    checks++;
                    if (op[i][j] !== exp_m[i][j]) begin errors++; $display("FAIL rand_byte iter%0d [%0d][%0d] got %h want %h", n, i, j, op[i][j], exp_m[i][j]); end
                end
        end
        sbox_en = 1'b0;
    endtask

    task automatic test_async_reset;
        fill(8'h10); row_mask = 4'hF; col_mask = 4'hF; sbox_en = 1'b1;
        @(negedge aes_clk);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %0b want 1", valid); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (op[i][j] !== 8'h00) begin errors++; $display("FAIL arst_byte[%0d][%0d] got %h want 00", i, j, op[i][j]); end
            end
        @(negedge aes_clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL arst_hold_valid got %0b want 0", valid); end
        resetn = 1'b1; sbox_en = 1'b0;
        @(negedge aes_clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_sbox[a] = calc_sbox(8'(a));
        test_reset();
        test_all_zero();
        test_fips_row();
        test_single_mask();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sbox.md
Name: aes_sbox

Overview:
- Registered AES forward S-box substitution engine operating on a NO_ROWS x NO_COLS byte state matrix.
- Used by the AES encryption core for the SubBytes step.
- Row/column masks select which bytes are substituted; unselected bytes pass through unchanged.
- Result is registered, with a valid flag.

Parameters:
- NO_ROWS, default 4: rows in the state matrix; also the row mask width.
- NO_COLS, default 4: columns in the state matrix; also the column mask width.

Ports:
- aes_clk  input  1: clock; all state updates on its rising edge.
- resetn  input  1: reset, asynchronous, active-low.
- sbox_en  input  1: substitution enable, sampled on the rising edge of aes_clk.
- sbox_ip_char_matrix  input  8 x [NO_ROWS][NO_COLS]: input byte matrix, unpacked [NO_ROWS-1:0][NO_COLS-1:0].
- sbox_ip_char_row_mask  input  NO_ROWS: bit i=1 enables substitution in row i.
- sbox_ip_char_col_mask  input  NO_COLS: bit j=1 enables substitution in column j.
- sbox_op_char_matrix_valid  output  1: output matrix holds a result computed from a sampled input.
- sbox_op_char_matrix  output  8 x [NO_ROWS][NO_COLS]: registered output byte matrix.

Behaviour:
- Reset (resetn=0, asynchronous):
  - sbox_op_char_matrix_valid=0.
  - Every sbox_op_char_matrix byte=8'h00.
  - Holds while resetn is low.
- Lookup table:
  - Fixed 256-entry AES forward S-box (FIPS-197), combinational ROM.
  - One lookup instance per matrix element, so all elements are processed in parallel.
- Per-element selection, for each (i,j):
  - If row_mask[i] & col_mask[j] is 1: next = SBOX[ip[i][j]].
  - Otherwise: next = ip[i][j], passed unchanged.
- Rising edge with sbox_en=1:
  - All NO_ROWS*NO_COLS output bytes load their next values.
  - valid <= 1.
  - Latency is one clock from sampled inputs to output.
- Streaming: with sbox_en held high, a new matrix is sampled every cycle. Output always reflects the inputs of the previous edge; valid stays 1.
- Rising edge with sbox_en=0:
  - valid <= 0.
  - Output matrix holds its last value; it is not cleared.
- Masks all-ones: full SubBytes. Either mask all-zero: output equals input (pure register stage), still flagged valid.
- Mask and input changes are only observed at sampling edges. No combinational path from inputs to outputs.
- Reset asserted mid-operation: immediate clear of output and valid regardless of sbox_en.
- First valid after reset release: the first edge with sbox_en=1.
- No X propagation: every output bit is driven from reset onward.

Test Plan:
- Reset then release, sbox_en=0 for 3 cycles -> valid=0, all output bytes 8'h00.
- All input bytes 8'h00, masks all-ones, sbox_en=1 one cycle -> next cycle valid=1, all output bytes 8'h63.
- Input row 0 = {19,a0,9a,e9}, remaining bytes 8'hFF, masks all-ones -> row 0 out = {d4,e0,b8,1e}, others 8'h16.
- Input all 8'h53, row_mask=4'b0001, col_mask=4'b0100 -> only out[0][2]=8'hED, all others 8'h53.
- sbox_en=1 for two cycles with inputs all 8'h01 then all 8'hFF, then sbox_en=0 -> outputs 8'h7C, then 8'h16, then valid=0 with 8'h16 held.
- Assert resetn low asynchronously while valid=1 -> valid and all outputs 0 before the next clock edge.
